// File: rtl/sargantana_icache_pkg.sv
// Shared types and constants for the instruction-cache set RAM controller.
package sargantana_icache_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    FLUSH = 1'b1
  } ctrl_state_t;

  localparam int unsigned STARVE_LIMIT = 4;

endpackage

// File: rtl/sargantana_set_ram_ctrl.sv
// Arbitrates lookup reads and refill writes onto one set RAM port and runs a full
// zero-write invalidation sweep. SARGANTANA_SET_RAM_CTRL_STARVE_EN adds lookup anti-starvation.
module sargantana_set_ram_ctrl
  import sargantana_icache_pkg::*;
#(
  parameter int unsigned ICACHE_DEPTH = 64,
  parameter int unsigned SET_WIDHT    = 256,
  parameter int unsigned ADDR_WIDHT   = 6
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  flush_i,
  output logic                  flush_busy_o,
  output logic                  flush_done_o,
  input  logic                  lu_req_i,
  input  logic [ADDR_WIDHT-1:0] lu_addr_i,
  output logic                  lu_gnt_o,
  output logic                  lu_rvalid_o,
  output logic [SET_WIDHT-1:0]  lu_rdata_o,
  input  logic                  rf_req_i,
  input  logic [ADDR_WIDHT-1:0] rf_addr_i,
  input  logic [SET_WIDHT-1:0]  rf_data_i,
  output logic                  rf_gnt_o,
  output logic                  ram_req_o,
  output logic                  ram_we_o,
  output logic [ADDR_WIDHT-1:0] ram_addr_o,
  output logic [SET_WIDHT-1:0]  ram_wdata_o,
  input  logic [SET_WIDHT-1:0]  ram_rdata_i
);

  ctrl_state_t           state_q, state_d;
  logic [ADDR_WIDHT-1:0] flush_cnt_q, flush_cnt_d;
  logic                  flush_done_q, flush_done_d;
  logic                  lu_rvalid_q;
  logic                  rf_gnt, lu_gnt, lu_wins;

`ifdef SARGANTANA_SET_RAM_CTRL_STARVE_EN
  // The counter wraps on the STARVE_LIMIT-th refill grant and starve_q remembers it,
  // so the next contended cycle goes to the lookup.
  logic [1:0] starve_cnt_q, starve_cnt_d;
  logic       starve_q, starve_d;

  assign lu_wins = starve_q;

  always_comb begin
    starve_cnt_d = starve_cnt_q;
    starve_d     = starve_q;
    if (!lu_req_i || lu_gnt) begin
      starve_cnt_d = 2'd0;
      starve_d     = 1'b0;
    end else if (rf_gnt) begin
      if (starve_cnt_q == 2'(STARVE_LIMIT - 1)) begin
        starve_cnt_d = 2'd0;
        starve_d     = 1'b1;
      end else begin
        starve_cnt_d = starve_cnt_q + 2'd1;
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      starve_cnt_q <= 2'd0;
      starve_q     <= 1'b0;
    end else begin
      starve_cnt_q <= starve_cnt_d;
      starve_q     <= starve_d;
    end
  end
`else
  assign lu_wins = 1'b0;
`endif

  always_comb begin
    state_d      = state_q;
    flush_cnt_d  = flush_cnt_q;
    flush_done_d = 1'b0;
    rf_gnt       = 1'b0;
    lu_gnt       = 1'b0;
    ram_req_o    = 1'b0;
    ram_we_o     = 1'b0;
    ram_addr_o   = lu_addr_i;
    ram_wdata_o  = rf_data_i;
    case (state_q)
      IDLE: begin
        lu_gnt     = lu_req_i && (!rf_req_i || lu_wins);
        rf_gnt     = rf_req_i && !lu_gnt;
        ram_req_o  = rf_gnt || lu_gnt;
        ram_we_o   = rf_gnt;
        ram_addr_o = rf_gnt ? rf_addr_i : lu_addr_i;
        if (flush_i) state_d = FLUSH;
      end
      FLUSH: begin
        ram_req_o   = 1'b1;
        ram_we_o    = 1'b1;
        ram_addr_o  = flush_cnt_q;
        ram_wdata_o = '0;
        if (flush_cnt_q == ADDR_WIDHT'(ICACHE_DEPTH - 1)) begin
          state_d      = IDLE;
          flush_cnt_d  = '0;
          flush_done_d = 1'b1;
        end else begin
          flush_cnt_d = flush_cnt_q + ADDR_WIDHT'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q      <= IDLE;
      flush_cnt_q  <= '0;
      flush_done_q <= 1'b0;
      lu_rvalid_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      flush_cnt_q  <= flush_cnt_d;
      flush_done_q <= flush_done_d;
      lu_rvalid_q  <= lu_gnt;
    end
  end

  assign rf_gnt_o     = rf_gnt;
  assign lu_gnt_o     = lu_gnt;
  assign lu_rvalid_o  = lu_rvalid_q;
  assign lu_rdata_o   = ram_rdata_i;
  assign flush_busy_o = (state_q == FLUSH);
  assign flush_done_o = flush_done_q;

endmodule

// File: tb/tb_sargantana_set_ram_ctrl.sv
// Directed plus randomized bench for sargantana_set_ram_ctrl against a memory-level
// reference model; a behavioural registered-output RAM sits on the RAM port.
module tb_sargantana_set_ram_ctrl;
  import sargantana_icache_pkg::*;

  localparam int DEPTH = 64;
  localparam int AW    = 6;
  localparam int SW    = 256;

  logic          clk_i = 1'b0;
  logic          rst_i = 1'b0;
  logic          flush_i = 1'b0;
  logic          flush_busy_o, flush_done_o;
  logic          lu_req_i = 1'b0;
  logic [AW-1:0] lu_addr_i = '0;
  logic          lu_gnt_o, lu_rvalid_o;
  logic [SW-1:0] lu_rdata_o;
  logic          rf_req_i = 1'b0;
  logic [AW-1:0] rf_addr_i = '0;
  logic [SW-1:0] rf_data_i = '0;
  logic          rf_gnt_o;
  logic          ram_req_o, ram_we_o;
  logic [AW-1:0] ram_addr_o;
  logic [SW-1:0] ram_wdata_o;
  logic [SW-1:0] ram_rdata_i;

  always #5 clk_i = ~clk_i;

  sargantana_set_ram_ctrl dut (
    .clk_i(clk_i), .rst_i(rst_i), .flush_i(flush_i),
    .flush_busy_o(flush_busy_o), .flush_done_o(flush_done_o),
    .lu_req_i(lu_req_i), .lu_addr_i(lu_addr_i), .lu_gnt_o(lu_gnt_o),
    .lu_rvalid_o(lu_rvalid_o), .lu_rdata_o(lu_rdata_o),
    .rf_req_i(rf_req_i), .rf_addr_i(rf_addr_i), .rf_data_i(rf_data_i), .rf_gnt_o(rf_gnt_o),
    .ram_req_o(ram_req_o), .ram_we_o(ram_we_o), .ram_addr_o(ram_addr_o),
    .ram_wdata_o(ram_wdata_o), .ram_rdata_i(ram_rdata_i)
  );

  // Behavioural single-port RAM with registered read data.
  logic [SW-1:0] ram [DEPTH];
  always @(posedge clk_i) begin
    if (ram_req_o) begin
      if (ram_we_o) ram[ram_addr_o] <= ram_wdata_o;
      else          ram_rdata_i     <= ram[ram_addr_o];
    end
  end

  int busy_cnt = 0, done_cnt = 0, lu_cnt = 0;
  always @(negedge clk_i) begin
    if (flush_busy_o === 1'b1) busy_cnt++;
    if (flush_done_o === 1'b1) done_cnt++;
    if (lu_gnt_o === 1'b1) lu_cnt++;
  end

  int n_cmp = 0, n_mis = 0;

  // Reference model: expected memory image and controller-level status.
  logic [SW-1:0] m_mem [DEPTH];
  bit            m_val [DEPTH];
  bit            m_flushing = 0, m_done_now = 0, exp_rv = 0, exp_rd_ok = 0;
  int            m_idx = 0, m_streak = 0;
  logic [SW-1:0] exp_rd;

  task automatic check(input string tag, input logic [SW-1:0] obs, input logic [SW-1:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_mis++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step(input logic rq, input logic [AW-1:0] ra, input logic [SW-1:0] rd,
                      input logic lq, input logic [AW-1:0] la, input logic fl,
                      output logic rg, output logic lg);
    logic e_rg, e_lg, lu_wins;
    rf_req_i = rq; rf_addr_i = ra; rf_data_i = rd;
    lu_req_i = lq; lu_addr_i = la; flush_i = fl;
    @(negedge clk_i);
    check("rvalid", lu_rvalid_o, exp_rv);
    if (exp_rv && exp_rd_ok) check("rdata", lu_rdata_o, exp_rd);
    check("flush_busy", flush_busy_o, m_flushing);
    check("flush_done", flush_done_o, m_done_now);
    if (m_flushing) begin
      e_rg = 1'b0; e_lg = 1'b0;
      check("flush_ram_req", ram_req_o, 1);
      check("flush_we", ram_we_o, 1);
      check("flush_addr", ram_addr_o, m_idx);
      check("flush_wdata", ram_wdata_o, 0);
    end else begin
`ifdef SARGANTANA_SET_RAM_CTRL_STARVE_EN
      lu_wins = (m_streak >= STARVE_LIMIT);
`else
      lu_wins = 1'b0;
`endif
      e_lg = lq && (!rq || lu_wins);
      e_rg = rq && !e_lg;
      check("ram_req", ram_req_o, e_rg | e_lg);
      if (e_rg) begin
        check("rf_we", ram_we_o, 1);
        check("rf_addr", ram_addr_o, ra);
        check("rf_wdata", ram_wdata_o, rd);
      end else if (e_lg) begin
        check("lu_we", ram_we_o, 0);
        check("lu_addr", ram_addr_o, la);
      end
    end
    check("rf_gnt", rf_gnt_o, e_rg);
    check("lu_gnt", lu_gnt_o, e_lg);
    exp_rv    = e_lg;
    exp_rd    = m_mem[la];
    exp_rd_ok = m_val[la];
    if (e_rg) begin m_mem[ra] = rd; m_val[ra] = 1; end
    if (!lq || e_lg) m_streak = 0;
    else if (e_rg)   m_streak++;
    m_done_now = 0;
    if (m_flushing) begin
      m_mem[m_idx] = '0; m_val[m_idx] = 1;
      if (m_idx == DEPTH - 1) begin m_flushing = 0; m_idx = 0; m_done_now = 1; end
      else m_idx++;
    end else if (fl) begin
      m_flushing = 1;
    end
    rg = e_rg; lg = e_lg;
    @(posedge clk_i); #1;
  endtask

  task automatic do_reset(input int hold);
    rst_i = 1'b1; rf_req_i = 0; lu_req_i = 0; flush_i = 0;
    #1;
    check("rst_busy", flush_busy_o, 0);
    check("rst_done", flush_done_o, 0);
    check("rst_rvalid", lu_rvalid_o, 0);
    check("rst_gnts", {rf_gnt_o, lu_gnt_o}, 0);
    if (m_flushing) for (int i = m_idx; i < DEPTH; i++) m_val[i] = 0;
    m_flushing = 0; m_idx = 0; m_done_now = 0; m_streak = 0; exp_rv = 0;
    repeat (hold) @(posedge clk_i);
    #1 rst_i = 1'b0;
  endtask

  logic          g_r, g_l, p_r, p_l;
  logic [AW-1:0] r_a, l_a;
  logic [SW-1:0] r_d, pat;

  initial begin
    for (int i = 0; i < DEPTH; i++) m_val[i] = 0;
    #2 do_reset(3);
    step(0, 0, '0, 0, 0, 0, g_r, g_l);

    // Full invalidation sweep with both requesters held high throughout.
    busy_cnt = 0; done_cnt = 0;
    step(0, 0, '0, 0, 0, 1, g_r, g_l);
    for (int i = 0; i < DEPTH; i++) step(1, 7, '1, 1, 9, 1, g_r, g_l);
    step(0, 0, '0, 0, 0, 0, g_r, g_l);
    check("sweep_busy_cycles", busy_cnt, DEPTH);
    check("sweep_done_pulses", done_cnt, 1);
    step(0, 0, '0, 1, 0, 0, g_r, g_l);
    step(0, 0, '0, 1, 17, 0, g_r, g_l);
    step(0, 0, '0, 1, 63, 0, g_r, g_l);
    step(0, 0, '0, 0, 0, 0, g_r, g_l);

    // Refill then lookup at index 5.
    pat = {32{8'hA5}};
    step(1, 5, pat, 0, 0, 0, g_r, g_l);
    step(0, 0, '0, 1, 5, 0, g_r, g_l);
    step(0, 0, '0, 0, 0, 0, g_r, g_l);

    // Refill and lookup collide on index 3; retried lookup sees the new data.
    for (int k = 0; k < SW / 32; k++) pat[k*32 +: 32] = $urandom;
    step(1, 3, pat, 1, 3, 0, g_r, g_l);
    step(0, 0, '0, 1, 3, 0, g_r, g_l);
    step(0, 0, '0, 0, 0, 0, g_r, g_l);

    // Sustained contention.
    lu_cnt = 0;
    for (int i = 0; i < 15; i++) step(1, 1, pat, 1, 2, 0, g_r, g_l);
    step(0, 0, '0, 0, 0, 0, g_r, g_l);
`ifdef SARGANTANA_SET_RAM_CTRL_STARVE_EN
    check("contended_lookup_grants", lu_cnt, 3);
`else
    check("contended_lookup_grants", lu_cnt, 0);
`endif

    // Reset while the sweep is at index 20.
    done_cnt = 0;
    step(0, 0, '0, 0, 0, 1, g_r, g_l);
    for (int i = 0; i < 20; i++) step(0, 0, '0, 0, 0, 0, g_r, g_l);
    do_reset(2);
    for (int i = 0; i < 3; i++) step(0, 0, '0, 0, 0, 0, g_r, g_l);
    check("aborted_sweep_done", done_cnt, 0);
    step(1, 30, pat, 0, 0, 0, g_r, g_l);
    step(0, 0, '0, 1, 30, 0, g_r, g_l);
    step(0, 0, '0, 0, 0, 0, g_r, g_l);

    // Randomized traffic; requesters hold until granted.
    p_r = 0; p_l = 0; r_a = 0; l_a = 0; r_d = '0;
    for (int c = 0; c < 400; c++) begin
      if (!p_r) begin
        p_r = ($urandom % 2) == 1;
        r_a = AW'($urandom_range(0, 7));
        for (int k = 0; k < SW / 32; k++) r_d[k*32 +: 32] = $urandom;
      end
      if (!p_l) begin
        p_l = ($urandom % 2) == 1;
        l_a = AW'($urandom_range(0, 7));
      end
      step(p_r, r_a, r_d, p_l, l_a, ($urandom % 40) == 0, g_r, g_l);
      if (g_r) p_r = 0;
      if (g_l) p_l = 0;
    end
    for (int i = 0; i < DEPTH + 2; i++) step(0, 0, '0, 0, 0, 0, g_r, g_l);

    step(0, 0, '0, 0, 0, 1, g_r, g_l);
    for (int i = 0; i < DEPTH + 1; i++) step(0, 0, '0, 0, 0, 0, g_r, g_l);
    for (int i = 0; i < 6; i++) step(0, 0, '0, 1, AW'($urandom_range(0, DEPTH - 1)), 0, g_r, g_l);
    step(0, 0, '0, 0, 0, 0, g_r, g_l);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
